// File: rtl/i2s_frame_serializer_pkg.sv
// Shared types and constants for the I2S sender: FSM state encoding, default widths
// and slot-position helpers reused by the generator and a future receiver.
package i2s_frame_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  localparam int unsigned I2S_DEF_DATA_WIDTH = 32'd24;
  localparam int unsigned I2S_DEF_SLOT_WIDTH = 32'd32;
  localparam int unsigned I2S_DEF_BCLK_DIV   = 32'd4;

  // Philips I2S: the MSB sits one BCLK after the LRCK edge.
  localparam int unsigned I2S_POS_DELAY = 32'd1;

  function automatic int unsigned i2s_last_data_pos(input int unsigned data_width);
    return I2S_POS_DELAY + data_width - 32'd1;
  endfunction

endpackage

// File: rtl/i2s_frame_serializer_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_DIV clk while run is high, and returns to
// phase 0 (bclk low, divider cleared) whenever run is low.
module i2s_frame_serializer_bclk_gen #(
  parameter int unsigned BCLK_DIV = 32'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int unsigned DIV_W = (BCLK_DIV > 32'd1) ? $clog2(BCLK_DIV) : 32'd1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic             tc_s;

  assign tc_s      = run & (div_cnt_r == DIV_LAST);
  assign fall_tick = tc_s & bclk_r;
  assign rise_tick = tc_s & ~bclk_r;
  assign bclk      = bclk_r;

  // Divider and bit clock state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
    end else if (!run) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= 1'b0;
    end else if (tc_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/i2s_frame_serializer.sv
// Pairs 24-bit words into L/R frames and shifts them out as Philips I2S.
// Optional macro I2S_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_frame_serializer
  import i2s_frame_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = I2S_DEF_DATA_WIDTH,
  parameter int unsigned SLOT_WIDTH = I2S_DEF_SLOT_WIDTH,
  parameter int unsigned BCLK_DIV   = I2S_DEF_BCLK_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  underrun,
  output logic                  frame_start
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int unsigned CNT_W = $clog2(32'd2 * SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(32'd2 * SLOT_WIDTH - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SLOT_C      = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] POS_FIRST_C = CNT_W'(I2S_POS_DELAY);
  localparam logic [CNT_W-1:0] POS_LAST_C  = CNT_W'(i2s_last_data_pos(DATA_WIDTH));

  i2s_state_e            state_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  lrck_r, sdata_r, underrun_r, frame_start_r;
  logic [DATA_WIDTH-1:0] sh_l_r, sh_r_r;
  logic [DATA_WIDTH-1:0] buf_l_r, buf_r_r;
  logic                  buf_l_full_r, buf_r_full_r, wr_sel_r;

  logic                  bclk_s, fall_tick_s, bclk_rise_unused_s;
  logic                  run_s, pair_ready_s, accept_s, load_s;
  logic [CNT_W-1:0]      next_cnt_s, next_pos_s;
  logic                  next_lrck_s, data_bit_s;

  assign run_s        = (state_r == ST_RUN);
  assign pair_ready_s = buf_l_full_r & buf_r_full_r;
  assign s_ready      = rst_n & ~pair_ready_s;
  assign accept_s     = s_valid & s_ready;
  assign load_s       = enable & pair_ready_s &
                        (~run_s | (fall_tick_s & (bit_cnt_r == CNT_LAST)));

  i2s_frame_serializer_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run_s),
    .bclk      (bclk_s),
    .fall_tick (fall_tick_s),
    .rise_tick (bclk_rise_unused_s)
  );

  // Next slot position: channel select and whether it carries a sample bit.
  always_comb begin
    next_cnt_s  = bit_cnt_r + CNT_ONE;
    next_pos_s  = {CNT_W{1'b0}};
    next_lrck_s = 1'b0;
    if (bit_cnt_r == CNT_LAST) begin
      next_cnt_s = {CNT_W{1'b0}};
    end else begin
      next_cnt_s = bit_cnt_r + CNT_ONE;
    end
    if (next_cnt_s >= SLOT_C) begin
      next_lrck_s = 1'b1;
      next_pos_s  = next_cnt_s - SLOT_C;
    end else begin
      next_lrck_s = 1'b0;
      next_pos_s  = next_cnt_s;
    end
    data_bit_s = (next_pos_s >= POS_FIRST_C) && (next_pos_s <= POS_LAST_C);
  end

  // Frame FSM with serializer shift registers and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {CNT_W{1'b0}};
      lrck_r        <= 1'b0;
      sdata_r       <= 1'b0;
      underrun_r    <= 1'b0;
      frame_start_r <= 1'b0;
      sh_l_r        <= {DATA_WIDTH{1'b0}};
      sh_r_r        <= {DATA_WIDTH{1'b0}};
    end else begin
      underrun_r    <= 1'b0;
      frame_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= {CNT_W{1'b0}};
          lrck_r    <= 1'b0;
          sdata_r   <= 1'b0;
          if (load_s) begin
            sh_l_r        <= buf_l_r;
            sh_r_r        <= buf_r_r;
            frame_start_r <= 1'b1;
            state_r       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fall_tick_s) begin
            if (bit_cnt_r == CNT_LAST) begin
              bit_cnt_r <= {CNT_W{1'b0}};
              lrck_r    <= 1'b0;
              sdata_r   <= 1'b0;
              if (!enable) begin
                state_r <= ST_IDLE;
              end else if (load_s) begin
                sh_l_r        <= buf_l_r;
                sh_r_r        <= buf_r_r;
                frame_start_r <= 1'b1;
              end else begin
                sh_l_r     <= {DATA_WIDTH{1'b0}};
                sh_r_r     <= {DATA_WIDTH{1'b0}};
                underrun_r <= 1'b1;
              end
            end else begin
              bit_cnt_r <= next_cnt_s;
              lrck_r    <= next_lrck_s;
              if (!data_bit_s) begin
                sdata_r <= 1'b0;
              end else if (next_lrck_s) begin
                sdata_r <= sh_r_r[DATA_WIDTH-1];
                sh_r_r  <= {sh_r_r[DATA_WIDTH-2:0], 1'b0};
              end else begin
                sdata_r <= sh_l_r[DATA_WIDTH-1];
                sh_l_r  <= {sh_l_r[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Input pair buffer; a word accepted during a load lands after the transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_l_r      <= {DATA_WIDTH{1'b0}};
      buf_r_r      <= {DATA_WIDTH{1'b0}};
      buf_l_full_r <= 1'b0;
      buf_r_full_r <= 1'b0;
      wr_sel_r     <= 1'b0;
    end else begin
      if (load_s) begin
        buf_l_full_r <= 1'b0;
        buf_r_full_r <= 1'b0;
      end
      if (accept_s) begin
        wr_sel_r <= ~wr_sel_r;
        if (wr_sel_r) begin
          buf_r_r      <= s_data;
          buf_r_full_r <= 1'b1;
        end else begin
          buf_l_r      <= s_data;
          buf_l_full_r <= 1'b1;
        end
      end
    end
  end

`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_r;

  // Saturating count of underrun pulses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_cnt_r <= 16'h0000;
    end else if (underrun_r && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end
  end

  assign underrun_count = underrun_cnt_r;
`endif

  assign i2s_bclk    = bclk_s;
  assign i2s_lrck    = lrck_r;
  assign i2s_sdata   = sdata_r;
  assign underrun    = underrun_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Directed self-checking bench for i2s_frame_serializer (24/32, BCLK_DIV=2).
module tb_i2s_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid;
  logic [23:0] s_data;
  logic        s_ready, i2s_bclk, i2s_lrck, i2s_sdata, underrun, frame_start;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic rdy_d = 1'b0;

  localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

  i2s_frame_serializer #(
    .DATA_WIDTH (24),
    .SLOT_WIDTH (32),
    .BCLK_DIV   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdata   (i2s_sdata),
    .underrun    (underrun),
    .frame_start (frame_start)
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rdy_d <= s_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // Called at a negedge; returns at a negedge after the word was taken.
  task automatic push(input logic [23:0] d);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("push_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // sel 0 = frame_start, 1 = underrun; at = cycle of the pulse or -1.
  task automatic wait_event(input int sel, input int bound, output int at);
    at = -1;
    for (int t = 0; t < bound; t++) begin
      @(negedge clk);
      if ((sel == 0 && frame_start) || (sel == 1 && underrun)) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Samples sdata/lrck on 64 BCLK rising edges; drops enable at rise number drop_at.
  task automatic capture_frame(input int drop_at, output logic [63:0] d, output logic [63:0] lr);
    int   n = 0;
    logic prev;
    d = '0;
    lr = '0;
    prev = i2s_bclk;
    for (int t = 0; t < 600 && n < 64; t++) begin
      @(negedge clk);
      if (i2s_bclk && !prev) begin
        d  = {d[62:0], i2s_sdata};
        lr = {lr[62:0], i2s_lrck};
        n++;
        if (n == drop_at) enable = 1'b0;
      end
      prev = i2s_bclk;
    end
    check("cap_bits", n, 64);
  endtask

  task automatic watch_idle(input int n, output int act);
    act = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (i2s_bclk | i2s_lrck | i2s_sdata | underrun | frame_start) act++;
    end
  endtask

  initial begin
    int at, tprev, act;
    logic [63:0] d, lr, d2, lr2, d3, lr3;

    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 24'h0;
    repeat (4) @(negedge clk);
    check("rst_outs", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, frame_start}, 0);
    check("rst_ready", s_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);

    push(24'h0B7700);
    push(24'hA1DD00);
    check("ready_full", s_ready, 0);
    watch_idle(10, act);
    check("idle_no_enable", act, 0);

    enable = 1'b1;
    wait_event(0, 20, at);
    check("fs1_seen", at >= 0, 1);
    fork
      push(24'h000005);
      capture_frame(0, d, lr);
    join
    check("frame1_data", d, exp_frame(24'h0B7700, 24'hA1DD00));
    check("frame1_lrck", lr, LR_EXP);

    wait_event(1, 20, at);
    check("underrun1_seen", at >= 0, 1);
    fork
      begin
        @(negedge clk);
        check("underrun_width", underrun, 0);
      end
      push(24'h000006);
      capture_frame(0, d2, lr2);
    join
    check("frame2_zero", d2, 64'h0);
    check("frame2_lrck", lr2, LR_EXP);

    wait_event(0, 40, at);
    check("fs3_seen", at >= 0, 1);
    tprev = at;
    fork
      capture_frame(0, d3, lr3);
      for (int i = 0; i < 20; i++) push(24'(i));
      begin
        int at2;
        logic [63:0] dm, lrm;
        for (int k = 0; k < 10; k++) begin
          wait_event(0, 600, at2);
          check("stream_fs_seen", at2 >= 0, 1);
          check("frame_spacing", at2 - tprev, 256);
          check("ready_rise", {rdy_d, s_ready}, 2'b01);
          tprev = at2;
          capture_frame(0, dm, lrm);
          check("stream_data", dm, exp_frame(24'(2 * k), 24'(2 * k + 1)));
        end
      end
    join
    check("frame3_data", d3, exp_frame(24'h000005, 24'h000006));

    wait_event(1, 40, at);
    check("underrun2_seen", at >= 0, 1);
    push(24'h123456);
    push(24'h654321);
    wait_event(0, 600, at);
    check("fs_drop_seen", at >= 0, 1);
    capture_frame(11, d, lr);
    check("drop_frame_data", d, exp_frame(24'h123456, 24'h654321));
    check("drop_frame_lrck", lr, LR_EXP);
    repeat (3) @(negedge clk);
    watch_idle(40, act);
    check("idle_after_drop", act, 0);

    enable = 1'b1;
    watch_idle(10, act);
    enable = 1'b0;
    watch_idle(10, at);
    check("idle_toggle_empty", act + at, 0);

    enable = 1'b1;
    push(24'h111111);
    push(24'h222222);
    wait_event(0, 40, at);
    check("fs_rst_seen", at >= 0, 1);
    repeat (165) @(negedge clk);
    check("pre_reset_lrck", i2s_lrck, 1);
    push(24'h333333);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", {i2s_bclk, i2s_lrck, i2s_sdata, underrun, frame_start}, 0);
    check("midrst_ready", s_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", s_ready, 1);
    push(24'hABCDEF);
    push(24'h135790);
    wait_event(0, 40, at);
    check("fs_post_rst_seen", at >= 0, 1);
    capture_frame(0, d, lr);
    check("post_rst_data", d, exp_frame(24'hABCDEF, 24'h135790));
    for (int u = 0; u < 3; u++) begin
      wait_event(1, 600, at);
      check("forced_underrun_seen", at >= 0, 1);
    end
`ifdef I2S_UNDERRUN_CNT_EN
    @(negedge clk);
    check("underrun_count", underrun_count, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
